// File: rtl/cpu5_instenc_pkg.sv
// Shared constants for the cpu5 instruction encoder: request kinds, RV32I
// opcode/funct fields, format selectors and the canonical NOP word.
package cpu5_instenc_pkg;

  typedef enum logic [2:0] {
    KIND_LW   = 3'd0,
    KIND_SW   = 3'd1,
    KIND_ADDI = 3'd2,
    KIND_ADD  = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_BNE  = 3'd5,
    KIND_JALR = 3'd6,
    KIND_RSVD = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    CPU5_IMMTYPE_I    = 3'd0,
    CPU5_IMMTYPE_S    = 3'd1,
    CPU5_IMMTYPE_R    = 3'd2,
    CPU5_IMMTYPE_B    = 3'd3,
    CPU5_IMMTYPE_NONE = 3'd4
  } immtype_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [31:0] CPU5_NOP = 32'h0000_0013;

endpackage

// File: rtl/cpu5_instenc_if.sv
// Request and instruction-memory write bus of the cpu5 instruction encoder.
interface cpu5_instenc_if #(
  parameter int AW = 32
);
  // Both channels are strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; valid never waits on ready, and a
  // raised valid keeps its payload stable until the transfer happens.
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_kind;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [31:0]   req_imm;
  logic          load_addr_en;
  logic [AW-1:0] load_addr;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [15:0]   inst_count;
  logic          err_illegal;

  modport master (
    output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm,
    output load_addr_en, load_addr, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata, inst_count, err_illegal
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm,
    input  load_addr_en, load_addr, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata, inst_count, err_illegal
  );
endinterface

// File: rtl/cpu5_instenc_pack.sv
// Combinational RV32I packer: maps a symbolic request to {word, illegal}.
// Also usable on its own as a golden encoder.
module cpu5_instenc_pack
  import cpu5_instenc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  logic [6:0] op;
  logic [2:0] f3;
  immtype_e   fmt;
  logic       fits12;
  logic       fits13;

  // Range tests as sign-extension checks; branch offsets must also be even.
  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}}) && !imm[0];

  always_comb begin
    op  = OP_IMM;
    f3  = 3'b000;
    fmt = CPU5_IMMTYPE_NONE;
    case (kind_e'(kind))
      KIND_LW:   begin op = OP_LOAD;   f3 = F3_LW;   fmt = CPU5_IMMTYPE_I; end
      KIND_SW:   begin op = OP_STORE;  f3 = F3_SW;   fmt = CPU5_IMMTYPE_S; end
      KIND_ADDI: begin op = OP_IMM;    f3 = F3_ADDI; fmt = CPU5_IMMTYPE_I; end
      KIND_ADD:  begin op = OP_REG;    f3 = F3_ADD;  fmt = CPU5_IMMTYPE_R; end
      KIND_BEQ:  begin op = OP_BRANCH; f3 = F3_BEQ;  fmt = CPU5_IMMTYPE_B; end
      KIND_BNE:  begin op = OP_BRANCH; f3 = F3_BNE;  fmt = CPU5_IMMTYPE_B; end
      KIND_JALR: begin op = OP_JALR;   f3 = F3_JALR; fmt = CPU5_IMMTYPE_I; end
      default:   ;
    endcase

    word    = '0;
    illegal = 1'b1;
    case (fmt)
      CPU5_IMMTYPE_I: begin
        word    = {imm[11:0], rs1, f3, rd, op};
        illegal = !fits12;
      end
      CPU5_IMMTYPE_S: begin
        word    = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        illegal = !fits12;
      end
      CPU5_IMMTYPE_R: begin
        word    = {F7_ADD, rs2, rs1, f3, rd, op};
        illegal = 1'b0;
      end
      CPU5_IMMTYPE_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        illegal = !fits13;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu5_instenc.sv
// cpu5 instruction encoder top: one-entry output register, write-address
// counter, completed-write counter and sticky illegal-request flag.
module cpu5_instenc
  import cpu5_instenc_pkg::*;
#(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] ADDR_RESET = '0
) (
  input  logic           clk,
  input  logic           reset,
  cpu5_instenc_if.slave  bus
);
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic [AW-1:0] wr_addr;
  logic [15:0]   cnt;
  logic          err;

  logic          req_ready;
  logic          wr_fire;
  logic          req_fire;
  logic          load_apply;
  logic [AW-1:0] acc_addr;
  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          unused_addr_lsb;

  cpu5_instenc_pack u_pack (
    .kind    (bus.req_kind),
    .rd      (bus.req_rd),
    .rs1     (bus.req_rs1),
    .rs2     (bus.req_rs2),
    .imm     (bus.req_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign req_ready  = !bus.load_addr_en && (!out_valid || bus.imem_ready);
  assign wr_fire    = out_valid && bus.imem_ready;
  assign req_fire   = bus.req_valid && req_ready;
  assign load_apply = bus.load_addr_en && !out_valid;
  // When the pending write drains in the same cycle, the new word takes the
  // following address so streaming keeps one instruction per cycle.
  assign acc_addr   = wr_fire ? wr_addr + AW'(4) : wr_addr;
  assign unused_addr_lsb = ^bus.load_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= ADDR_RESET;
      out_data  <= '0;
      wr_addr   <= ADDR_RESET;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      if (wr_fire) begin
        out_valid <= 1'b0;
        wr_addr   <= wr_addr + AW'(4);
        cnt       <= cnt + 16'd1;
      end
      if (load_apply) begin
        wr_addr <= {bus.load_addr[AW-1:2], 2'b00};
      end
      if (req_fire) begin
        if (enc_illegal) begin
          err <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_addr  <= acc_addr;
          out_data  <= enc_word;
        end
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.imem_we     = out_valid;
  assign bus.imem_addr   = out_addr;
  assign bus.imem_wdata  = out_data;
  assign bus.inst_count  = cnt;
  assign bus.err_illegal = err;
endmodule

// File: tb/tb_cpu5_instenc.sv
// Self-checking bench for cpu5_instenc: directed test-plan cases with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_cpu5_instenc;
  import cpu5_instenc_pkg::*;

  localparam int            AW         = 32;
  localparam logic [AW-1:0] ADDR_RESET = '0;
  localparam int            BOUND[10]  = '{-2048, 2047, 2048, -2049, -4096,
                                           4094, 4095, 4096, -4098, -4097};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   rdy_mode = 1;
  int   checks = 0;
  int   failures = 0;

  cpu5_instenc_if #(.AW(AW)) bus();

  cpu5_instenc #(.AW(AW), .ADDR_RESET(ADDR_RESET)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset / write-side readiness ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.imem_ready = 1'b0;
      1:       bus.imem_ready = 1'b1;
      default: bus.imem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {illegal, word}, built from field positions with shifts.
  function automatic logic [32:0] model_enc(int kind, int rd, int rs1, int rs2, int imm);
    logic [31:0] u, w, f_rd, f_rs1, f_rs2, f3, op;
    bit bad;
    u = imm;
    f_rd  = 32'(rd & 31) << 7;
    f_rs1 = 32'(rs1 & 31) << 15;
    f_rs2 = 32'(rs2 & 31) << 20;
    w = 0; bad = 1'b0;
    case (kind)
      0: begin op = 32'h03; f3 = 32'd2; end
      1: begin op = 32'h23; f3 = 32'd2; end
      2: begin op = 32'h13; f3 = 32'd0; end
      3: begin op = 32'h33; f3 = 32'd0; end
      4: begin op = 32'h63; f3 = 32'd0; end
      5: begin op = 32'h63; f3 = 32'd1; end
      6: begin op = 32'h67; f3 = 32'd0; end
      default: begin op = 0; f3 = 0; end
    endcase
    f3 = f3 << 12;
    if (kind == 0 || kind == 2 || kind == 6) begin
      bad = (imm < -2048) || (imm > 2047);
      w = ((u & 32'hFFF) << 20) | f_rs1 | f3 | f_rd | op;
    end else if (kind == 1) begin
      bad = (imm < -2048) || (imm > 2047);
      w = (((u >> 5) & 32'h7F) << 25) | f_rs2 | f_rs1 | f3 | ((u & 32'h1F) << 7) | op;
    end else if (kind == 3) begin
      w = f_rs2 | f_rs1 | f3 | f_rd | op;
    end else if (kind == 4 || kind == 5) begin
      bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
      w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | f_rs2 | f_rs1 | f3 |
          (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | op;
    end else begin
      bad = 1'b1;
    end
    return {bad, w};
  endfunction

  // ---------------- scoreboard and per-cycle compare ----------------
  logic [63:0]   exp_q[$];
  logic [63:0]   lit_q[$];
  logic [AW-1:0] m_next;
  int unsigned   m_count;
  bit            m_err;
  bit            armed = 1'b0;
  bit            was_rst = 1'b0;
  bit            pend;
  bit            exp_rdy;
  logic [32:0]   enc;
  logic [63:0]   head;

  always @(negedge clk) begin
    pend    = (exp_q.size() != 0);
    exp_rdy = !bus.load_addr_en && (!pend || bus.imem_ready);
    if (armed) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("imem_we", 32'(bus.imem_we), 32'(pend));
      if (pend && bus.imem_we) begin
        head = exp_q[0];
        chk("imem_addr", bus.imem_addr, head[63:32]);
        chk("imem_wdata", bus.imem_wdata, head[31:0]);
      end
      chk("inst_count", 32'(bus.inst_count), 32'(m_count[15:0]));
      chk("err_illegal", 32'(bus.err_illegal), 32'(m_err));
      if (was_rst) begin
        chk("rst_addr", bus.imem_addr, ADDR_RESET);
        chk("rst_wdata", bus.imem_wdata, 32'h0);
      end
    end
    was_rst = reset;
    if (reset) begin
      exp_q.delete();
      m_next  = ADDR_RESET;
      m_count = 0;
      m_err   = 1'b0;
      armed   = 1'b1;
    end else if (armed) begin
      if (pend && bus.imem_ready) begin
        head = exp_q.pop_front();
        m_count++;
        if (lit_q.size() != 0) begin
          head = lit_q.pop_front();
          chk("lit_addr", bus.imem_addr, head[63:32]);
          chk("lit_data", bus.imem_wdata, head[31:0]);
        end
      end
      if (bus.load_addr_en && !pend) m_next = {bus.load_addr[AW-1:2], 2'b00};
      if (bus.req_valid && exp_rdy) begin
        enc = model_enc(int'(bus.req_kind), int'(bus.req_rd), int'(bus.req_rs1),
                        int'(bus.req_rs2), int'(bus.req_imm));
        if (enc[32]) m_err = 1'b1;
        else begin
          exp_q.push_back({m_next, enc[31:0]});
          m_next = m_next + AW'(4);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int kind, int rd, int rs1, int rs2, int imm);
    bit got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_kind  = 3'(kind);
    bus.req_rd    = 5'(rd);
    bus.req_rs1   = 5'(rs1);
    bus.req_rs2   = 5'(rs2);
    bus.req_imm   = imm;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      idle = !bus.imem_we;
      step();
      if (idle) break;
    end
    if (!idle) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(logic [AW-1:0] a);
    bit done = 1'b0;
    bus.load_addr_en = 1'b1;
    bus.load_addr    = a;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      done = !bus.imem_we;
      step();
      if (done) break;
    end
    bus.load_addr_en = 1'b0;
    if (!done) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic int rand_imm(int kind);
    int r = int'($urandom_range(0, 9));
    int v;
    if (r < 6) begin
      v = int'($urandom_range(0, 4095)) - 2048;
      if ((kind == 4 || kind == 5) && r < 4) v = (v & -2) * 2;
    end else if (r < 8) begin
      v = BOUND[$urandom_range(0, 9)];
    end else begin
      v = int'($urandom);
    end
    return v;
  endfunction

  // ---------------- main sequence ----------------
  logic [32:0] pin;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_kind     = '0;
    bus.req_rd       = '0;
    bus.req_rs1      = '0;
    bus.req_rs2      = '0;
    bus.req_imm      = '0;
    bus.load_addr_en = 1'b0;
    bus.load_addr    = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    pin = model_enc(4, 0, 1, 2, -8);
    chk("pin_beq_word", pin[31:0], 32'hFE208CE3);
    pin = model_enc(2, 0, 0, 0, 2048);
    chk("pin_addi_bad", 32'(pin[32]), 32'd1);

    // First instruction after reset.
    @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_we", 32'(bus.imem_we), 32'd0);
    step();
    lit_q.push_back({32'h0, 32'h00500093});
    send(2, 1, 0, 0, 5);
    @(negedge clk);
    chk("first_we", 32'(bus.imem_we), 32'd1);
    step();
    @(negedge clk);
    chk("first_count", 32'(bus.inst_count), 32'd1);
    step();

    // Back-to-back stream, branches and illegal requests.
    pulse_reset();
    lit_q.push_back({32'h00, 32'h002081B3});
    lit_q.push_back({32'h04, 32'h00812283});
    lit_q.push_back({32'h08, 32'h00512623});
    lit_q.push_back({32'h0C, 32'h000280E7});
    lit_q.push_back({32'h10, 32'hFE208CE3});
    lit_q.push_back({32'h14, 32'h00209363});
    send(3, 3, 1, 2, 0);
    send(0, 5, 2, 0, 8);
    send(1, 0, 2, 5, 12);
    send(6, 1, 5, 0, 0);
    send(4, 0, 1, 2, -8);
    send(5, 0, 1, 2, 6);
    drain();
    @(negedge clk);
    chk("err_before", 32'(bus.err_illegal), 32'd0);
    step();
    send(4, 0, 1, 2, 3);
    @(negedge clk);
    chk("err_beq_odd", 32'(bus.err_illegal), 32'd1);
    chk("no_write_odd", 32'(bus.imem_we), 32'd0);
    step();
    send(2, 0, 0, 0, 2048);
    lit_q.push_back({32'h18, 32'h80000013});
    send(2, 0, 0, 0, -2048);
    drain();

    // Write-side stall, then release with a new request in the same cycle.
    rdy_mode = 0;
    lit_q.push_back({32'h1C, 32'h00708113});
    send(2, 2, 1, 0, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_we", 32'(bus.imem_we), 32'd1);
      chk("stall_addr", bus.imem_addr, 32'h1C);
      chk("stall_data", bus.imem_wdata, 32'h00708113);
      step();
    end
    rdy_mode = 1;
    lit_q.push_back({32'h20, 32'h00310233});
    send(3, 4, 2, 3, 0);
    drain();

    // Address load ignores the low two bits.
    do_load(32'h103);
    lit_q.push_back({32'h100, 32'h00500093});
    send(2, 1, 0, 0, 5);
    drain();

    // Reset with a write pending.
    rdy_mode = 0;
    send(2, 1, 0, 0, 1);
    step();
    pulse_reset();
    @(negedge clk);
    chk("rst_mid_we", 32'(bus.imem_we), 32'd0);
    chk("rst_mid_addr", bus.imem_addr, ADDR_RESET);
    chk("rst_mid_count", 32'(bus.inst_count), 32'd0);
    step();
    rdy_mode = 1;
    chk("lit_drained", 32'(lit_q.size()), 32'd0);

    // Randomized traffic.
    rdy_mode = 2;
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 19));
      int k = int'($urandom_range(0, 7));
      if (r == 0) do_load(AW'($urandom));
      else if (r == 1) step();
      else send(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), rand_imm(k));
    end
    rdy_mode = 1;
    drain();
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
